pixel_line_buffer: RTL and testbench

- Streaming 3-row line buffer for the coin-detection pixel pipeline.
- Accepts one raster-order pixel per valid cycle.
- Emits a vertically aligned column of three pixels (row-2, row-1, current) plus a qualifier.
- The qualifier drives the en input of the downstream enable-gated register stage that feeds the 3x3 window / edge filter.

---
 rtl/pixel_line_buffer.sv | 157 +++++++++++++++
 tb/tb_pixel_line_buffer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_line_buffer.sv
// pixel_line_buffer: streaming 3-row line buffer for the coin-detection pipeline.
// Takes raster-order pixels and emits a vertically aligned column
// (two rows up, one row up, current) with a qualifier that drives the
// enable of the downstream 3x3 window register stage.
// Optional feature: define LINE_BUF_BORDER_EN to also emit columns while the
// first two rows fill, with the top border replicated.
module pixel_line_buffer #(
  parameter int PIX_W    = 8,
  parameter int LINE_LEN = 640,
  parameter int COL_W    = 10
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             s_rst,
  input  logic             in_vld,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pix,
  output logic             out_vld,
  output logic [PIX_W-1:0] out_top,
  output logic [PIX_W-1:0] out_mid,
  output logic [PIX_W-1:0] out_bot,
  output logic [COL_W-1:0] out_col,
  output logic             out_eol
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL0  = 2'd1,
    FILL1  = 2'd2,
    STREAM = 2'd3
  } state_t;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_LEN - 1);

  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             out_vld_q, out_vld_d;
  logic [PIX_W-1:0] out_top_q, out_top_d;
  logic [PIX_W-1:0] out_mid_q, out_mid_d;
  logic [PIX_W-1:0] out_bot_q, out_bot_d;
  logic [COL_W-1:0] out_col_q, out_col_d;
  logic             out_eol_q, out_eol_d;

  // l1_mem holds the previous row, l0_mem the row before that.
  logic [PIX_W-1:0] l0_mem [LINE_LEN];
  logic [PIX_W-1:0] l1_mem [LINE_LEN];

  logic             start;
  logic             accept;
  state_t           eff_state;
  logic [COL_W-1:0] rd_col;
  logic             at_eol;
  logic [PIX_W-1:0] rd_l0;
  logic [PIX_W-1:0] rd_l1;

  // Qualify the incoming pixel; a start-of-frame pixel restarts at column 0
  // and is treated as the first pixel of FILL0 regardless of current state.
  always_comb begin
    start     = in_vld & in_sof;
    accept    = in_vld & (in_sof | (state_q != IDLE));
    rd_col    = start ? '0 : col_q;
    eff_state = start ? FILL0 : state_q;
    at_eol    = (rd_col == LAST_COL);
    rd_l0     = l0_mem[rd_col];
    rd_l1     = l1_mem[rd_col];
  end

  // Next-state, column counter and output register computation.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    out_vld_d = 1'b0;
    out_top_d = out_top_q;
    out_mid_d = out_mid_q;
    out_bot_d = out_bot_q;
    out_col_d = out_col_q;
    out_eol_d = out_eol_q;

    if (s_rst) begin
      state_d   = IDLE;
      col_d     = '0;
      out_top_d = '0;
      out_mid_d = '0;
      out_bot_d = '0;
      out_col_d = '0;
      out_eol_d = 1'b0;
    end else if (accept) begin
      col_d = at_eol ? '0 : rd_col + COL_W'(1);

      state_d = eff_state;
      if (at_eol) begin
        case (eff_state)
          FILL0:   state_d = FILL1;
          FILL1:   state_d = STREAM;
          default: state_d = eff_state;
        endcase
      end

      out_top_d = rd_l0;
      out_mid_d = rd_l1;
      out_bot_d = in_pix;
      out_col_d = rd_col;
      out_eol_d = at_eol;
`ifdef LINE_BUF_BORDER_EN
      // Replicate the top border so every input pixel yields a column.
      out_vld_d = 1'b1;
      if (eff_state == FILL0) begin
        out_top_d = in_pix;
        out_mid_d = in_pix;
      end else if (eff_state == FILL1) begin
        out_top_d = rd_l1;
      end
`else
      out_vld_d = (eff_state == STREAM);
`endif
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_q   <= IDLE;
      col_q     <= '0;
      out_vld_q <= 1'b0;
      out_top_q <= '0;
      out_mid_q <= '0;
      out_bot_q <= '0;
      out_col_q <= '0;
      out_eol_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      out_vld_q <= out_vld_d;
      out_top_q <= out_top_d;
      out_mid_q <= out_mid_d;
      out_bot_q <= out_bot_d;
      out_col_q <= out_col_d;
      out_eol_q <= out_eol_d;
    end
  end

  // Line memories: shift the column down one row (read-before-write), no reset.
  always_ff @(posedge clk) begin
    if (accept && !s_rst) begin
      l0_mem[rd_col] <= rd_l1;
      l1_mem[rd_col] <= in_pix;
    end
  end

  assign out_vld = out_vld_q;
  assign out_top = out_top_q;
  assign out_mid = out_mid_q;
  assign out_bot = out_bot_q;
  assign out_col = out_col_q;
  assign out_eol = out_eol_q;

endmodule

// File: tb/tb_pixel_line_buffer.sv
// tb_pixel_line_buffer: scoreboard bench for pixel_line_buffer (LINE_LEN=4).
// Works in both builds; LINE_BUF_BORDER_EN selects the border expectations.
module tb_pixel_line_buffer;

  localparam int PIX_W    = 8;
  localparam int LINE_LEN = 4;
  localparam int COL_W    = 2;
`ifdef LINE_BUF_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  typedef logic [27:0] obs_t; // {vld, top, mid, bot, col, eol}
  typedef struct {
    obs_t val;
    obs_t mask;
  } exp_t;

  localparam obs_t MASK_ALL = '1;
  localparam obs_t MASK_NO_TM = {1'b1, 16'h0000, 11'h7FF};

  logic             clk = 1'b0;
  logic             a_rst = 1'b0;
  logic             s_rst = 1'b0;
  logic             in_vld = 1'b0;
  logic             in_sof = 1'b0;
  logic [PIX_W-1:0] in_pix = '0;
  logic             out_vld;
  logic [PIX_W-1:0] out_top;
  logic [PIX_W-1:0] out_mid;
  logic [PIX_W-1:0] out_bot;
  logic [COL_W-1:0] out_col;
  logic             out_eol;

  int checks = 0;
  int passed = 0;

  exp_t sb_q[$];

  // Reference model: frame-relative pixel history.
  bit         m_active = 1'b0;
  int         m_n = 0;
  logic [7:0] m_hist [0:255];
  logic [7:0] m_top = '0, m_mid = '0, m_bot = '0;
  logic [1:0] m_col = '0;
  logic       m_eol = 1'b0;
  bit         m_known = 1'b1;

  pixel_line_buffer #(
    .PIX_W   (PIX_W),
    .LINE_LEN(LINE_LEN),
    .COL_W   (COL_W)
  ) dut (
    .clk    (clk),
    .a_rst  (a_rst),
    .s_rst  (s_rst),
    .in_vld (in_vld),
    .in_sof (in_sof),
    .in_pix (in_pix),
    .out_vld(out_vld),
    .out_top(out_top),
    .out_mid(out_mid),
    .out_bot(out_bot),
    .out_col(out_col),
    .out_eol(out_eol)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    return {out_vld, out_top, out_mid, out_bot, out_col, out_eol};
  endfunction

  function automatic void model_clear();
    m_active = 1'b0;
    m_n = 0;
    m_top = '0; m_mid = '0; m_bot = '0; m_col = '0; m_eol = 1'b0;
    m_known = 1'b1;
  endfunction

  // Drive one cycle, push the expected post-edge outputs, return 1 ns after the edge.
  task automatic step(input logic vld, input logic sof, input logic [7:0] pix, input logic srst);
    logic ev;
    exp_t e;
    @(negedge clk);
    in_vld = vld; in_sof = sof; in_pix = pix; s_rst = srst;
    ev = 1'b0;
    if (srst) begin
      model_clear();
    end else if (vld && (sof || m_active)) begin
      if (sof) begin
        m_active = 1'b1;
        m_n = 0;
      end
      m_hist[m_n % 256] = pix;
      m_col = 2'(m_n % LINE_LEN);
      m_eol = ((m_n % LINE_LEN) == LINE_LEN - 1);
      m_bot = pix;
      if (m_n >= 2 * LINE_LEN) begin
        m_top = m_hist[(m_n - 2 * LINE_LEN) % 256];
        m_mid = m_hist[(m_n - LINE_LEN) % 256];
        ev = 1'b1;
        m_known = 1'b1;
      end else if (m_n >= LINE_LEN) begin
        m_top = m_hist[(m_n - LINE_LEN) % 256];
        m_mid = m_top;
        ev = BORDER;
        m_known = BORDER;
      end else begin
        m_top = pix;
        m_mid = pix;
        ev = BORDER;
        m_known = BORDER;
      end
      m_n++;
    end
    e.val  = {ev, m_top, m_mid, m_bot, m_col, m_eol};
    e.mask = m_known ? MASK_ALL : MASK_NO_TM;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    in_vld = 1'b0; in_sof = 1'b0; s_rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    obs_t o;
    #2 a_rst = 1'b1;
    #5;
    o = observe();
    checks++;
    if (o !== '0) $display("FAIL reset_state: got %h want 0", o);
    else passed++;
    @(negedge clk);
    a_rst = 1'b0;
    model_clear();
    // No sof yet: every pixel must be ignored.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 8'(8'hA0 + k), 1'b0);
      e = sb_q.pop_front();
      o = observe();
      checks++;
      if ((o & e.mask) !== (e.val & e.mask))
        $display("FAIL idle_ignore[%0d]: got %h want %h", k, o, e.val);
      else passed++;
    end
  endtask

  task automatic test_priming();
    exp_t e;
    obs_t o;
    for (int k = 0; k < 12; k++) begin
      step(1'b1, k == 0, 8'(k), 1'b0);
      e = sb_q.pop_front();
      o = observe();
      checks++;
      if ((o & e.mask) !== (e.val & e.mask))
        $display("FAIL priming[%0d]: got %h want %h", k, o, e.val);
      else passed++;
      if (k == 8) begin
        checks++;
        if ({out_vld, out_top, out_mid, out_bot, out_col} !== {1'b1, 8'h00, 8'h04, 8'h08, 2'd0})
          $display("FAIL first_column: got vld=%b top=%h mid=%h bot=%h col=%0d want 1/00/04/08/0",
                   out_vld, out_top, out_mid, out_bot, out_col);
        else passed++;
      end
      if (k == 11) begin
        checks++;
        if ({out_vld, out_eol, out_top, out_mid, out_bot} !== {1'b1, 1'b1, 8'h03, 8'h07, 8'h0B})
          $display("FAIL eol_column: got vld=%b eol=%b top=%h mid=%h bot=%h want 1/1/03/07/0B",
                   out_vld, out_eol, out_top, out_mid, out_bot);
        else passed++;
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    obs_t o;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, k == 0, 8'(8'h30 + k), 1'b0);
      e = sb_q.pop_front();
      o = observe();
      checks++;
      if ((o & e.mask) !== (e.val & e.mask))
        $display("FAIL pre_arst[%0d]: got %h want %h", k, o, e.val);
      else passed++;
    end
    // Pulse a_rst mid-cycle: outputs must clear without waiting for an edge.
    #2 a_rst = 1'b1;
    #1;
    o = observe();
    checks++;
    if (o !== '0) $display("FAIL arst_immediate: got %h want 0", o);
    else passed++;
    @(negedge clk);
    a_rst = 1'b0;
    model_clear();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 8'(8'h3A + k), 1'b0);
      e = sb_q.pop_front();
      o = observe();
      checks++;
      if ((o & e.mask) !== (e.val & e.mask))
        $display("FAIL post_arst_idle[%0d]: got %h want %h", k, o, e.val);
      else passed++;
    end
  endtask

  task automatic test_gapped();
    exp_t e;
    obs_t o;
    for (int k = 0; k < 24; k++) begin
      // Odd cycles are gaps; sof on a gap cycle must be ignored.
      if (k % 2 == 0) step(1'b1, k == 0, 8'(k / 2), 1'b0);
      else            step(1'b0, 1'b1, 8'hEE, 1'b0);
      e = sb_q.pop_front();
      o = observe();
      checks++;
      if ((o & e.mask) !== (e.val & e.mask))
        $display("FAIL gapped[%0d]: got %h want %h", k, o, e.val);
      else passed++;
    end
  endtask

  task automatic test_restart();
    exp_t e;
    obs_t o;
    // Restart on pixel 6 of a frame, then again later while streaming.
    for (int k = 0; k < 33; k++) begin
      if (k < 6)        step(1'b1, k == 0, 8'(8'h40 + k), 1'b0);
      else if (k < 20)  step(1'b1, k == 6, 8'(8'h50 + k - 6), 1'b0);
      else              step(1'b1, k == 20, 8'(8'h70 + k - 20), 1'b0);
      e = sb_q.pop_front();
      o = observe();
      checks++;
      if ((o & e.mask) !== (e.val & e.mask))
        $display("FAIL restart[%0d]: got %h want %h", k, o, e.val);
      else passed++;
      if (k == 14) begin
        checks++;
        if ({out_vld, out_top, out_col} !== {1'b1, 8'h50, 2'd0})
          $display("FAIL restart_top: got vld=%b top=%h col=%0d want 1/50/0", out_vld, out_top, out_col);
        else passed++;
      end
      if (k == 20) begin
        checks++;
        if ({out_vld, out_col} !== {BORDER, 2'd0})
          $display("FAIL restart_stream: got vld=%b col=%0d want %b/0", out_vld, out_col, BORDER);
        else passed++;
      end
    end
  endtask

  task automatic test_srst_collision();
    exp_t e;
    obs_t o;
    for (int k = 0; k < 15; k++) begin
      if (k < 10)       step(1'b1, k == 0, 8'(8'h80 + k), 1'b0);
      else if (k == 10) step(1'b1, 1'b0, 8'h8A, 1'b1);
      else              step(1'b1, 1'b0, 8'(8'h90 + k), 1'b0);
      e = sb_q.pop_front();
      o = observe();
      checks++;
      if ((o & e.mask) !== (e.val & e.mask))
        $display("FAIL srst[%0d]: got %h want %h", k, o, e.val);
      else passed++;
    end
  endtask

  task automatic test_border();
    exp_t e;
    obs_t o;
    logic [7:0] pix [0:4];
    pix[0] = 8'h11; pix[1] = 8'h12; pix[2] = 8'h13; pix[3] = 8'h14; pix[4] = 8'h22;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, k == 0, pix[k], 1'b0);
      e = sb_q.pop_front();
      o = observe();
      checks++;
      if ((o & e.mask) !== (e.val & e.mask))
        $display("FAIL border[%0d]: got %h want %h", k, o, e.val);
      else passed++;
      if (k == 0) begin
        checks++;
        if (BORDER ? ({out_vld, out_top, out_mid, out_bot} !== {1'b1, 8'h11, 8'h11, 8'h11})
                   : (out_vld !== 1'b0))
          $display("FAIL border_row0: got vld=%b top=%h mid=%h bot=%h", out_vld, out_top, out_mid, out_bot);
        else passed++;
      end
      if (k == 4) begin
        checks++;
        if (BORDER ? ({out_vld, out_top, out_mid, out_bot} !== {1'b1, 8'h11, 8'h11, 8'h22})
                   : ({out_vld, out_bot} !== {1'b0, 8'h22}))
          $display("FAIL border_row1: got vld=%b top=%h mid=%h bot=%h", out_vld, out_top, out_mid, out_bot);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_priming();
    test_async_reset();
    test_gapped();
    test_restart();
    test_srst_collision();
    test_border();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Hard stop in case a task stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
